// File: rtl/slot_counter_pkg.sv
// Shared definitions for the slot counter bank: command op codes, mode bit
// positions, lane width, broadcast channel id and command FSM states.
package slot_counter_pkg;

  localparam int SLOT_W = 32;
  localparam logic [7:0] CHAN_BROADCAST = 8'hFF;

  localparam int MODE_DIR_BIT = 0;
  localparam int MODE_SAT_BIT = 1;

  typedef enum logic [1:0] {
    OP_NOP      = 2'd0,
    OP_CLEAR    = 2'd1,
    OP_LOAD     = 2'd2,
    OP_SET_MODE = 2'd3
  } cmd_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } cmd_state_t;

  // True when a command addressed to chan targets channel idx.
  function automatic logic chan_hit(input logic [7:0] chan, input int unsigned idx);
    logic [31:0] idx_v;
    idx_v = idx;
    return (chan == CHAN_BROADCAST) || (chan == idx_v[7:0]);
  endfunction

endpackage

// File: rtl/slot_counter_channel.sv
// One counter of the bank: count register, direction/saturate mode bits and
// registered terminal-count pulse. Host writes take priority over counting.
module slot_counter_channel
  import slot_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              slower_clock,
  input  logic              rst,
  input  logic              count_en,
  input  logic              wr_clear,
  input  logic              wr_load,
  input  logic              wr_mode,
  input  logic [SLOT_W-1:0] data,
  output logic [WIDTH-1:0]  count,
  output logic              tc
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};

  logic             dir;
  logic             sat;
  logic [WIDTH-1:0] count_step;
  logic             tc_step;
  logic             unused_data;

  assign unused_data = ^data;

  // Next count and terminal-count flag for a counting tick in the current mode.
  always_comb begin
    count_step = count;
    tc_step    = 1'b0;
    if (!dir) begin
      if (sat) begin
        if (count != MAX) begin
          count_step = count + ONE;
          tc_step    = (count == (MAX - ONE));
        end
      end else begin
        count_step = count + ONE;
        tc_step    = (count == MAX);
      end
    end else begin
      if (sat) begin
        if (count != ZERO) begin
          count_step = count - ONE;
          tc_step    = (count == ONE);
        end
      end else begin
        count_step = count - ONE;
        tc_step    = (count == ZERO);
      end
    end
  end

  // Count/mode registers; a host write suppresses both the tick and the pulse.
  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      count <= '0;
      dir   <= 1'b0;
      sat   <= 1'b0;
      tc    <= 1'b0;
    end else if (wr_clear) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (wr_load) begin
      count <= data[WIDTH-1:0];
      tc    <= 1'b0;
    end else if (wr_mode) begin
      dir   <= data[MODE_DIR_BIT];
      sat   <= data[MODE_SAT_BIT];
      tc    <= 1'b0;
    end else if (count_en) begin
      count <= count_step;
      tc    <= tc_step;
    end else begin
      tc    <= 1'b0;
    end
  end

endmodule

// File: rtl/slot_counter_bank.sv
// Bank of CHANNELS counters behind a valid/ready command port, with a shared
// free-running prescaler. Lanes are zero-extended to 32 bits for the slots.
// Optional macro SLOT_COUNTER_SNAPSHOT_EN adds a snapshot input and shadow
// registers so that count_out presents a coherent copy of all counters.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command to capture
// EXEC  | captured command is applied on the next edge, then back to IDLE
module slot_counter_bank
  import slot_counter_pkg::*;
#(
  parameter int CHANNELS = 5,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                       slower_clock,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        enable,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [7:0]                 cmd_chan,
  input  logic [31:0]                cmd_data,
  output logic [CHANNELS*SLOT_W-1:0] count_out,
  output logic [CHANNELS-1:0]        tc_pulse
`ifdef SLOT_COUNTER_SNAPSHOT_EN
  ,
  input  logic                       snapshot
`endif
);

  logic tick;

  if (PRESCALE == 1) begin : g_no_prescale
    assign tick = 1'b1;
  end else begin : g_prescale
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    logic [PS_W-1:0] ps;

    // Free-running prescaler, independent of any command activity.
    always_ff @(posedge slower_clock or posedge rst) begin
      if (rst)                ps <= '0;
      else if (ps == PS_LAST) ps <= '0;
      else                    ps <= ps + PS_W'(1);
    end

    assign tick = (ps == PS_LAST);
  end

  cmd_state_t          state;
  cmd_state_t          state_nxt;
  logic                ready_nxt;
  logic                accept;
  cmd_op_t             op_q;
  logic [7:0]          chan_q;
  logic [31:0]         data_q;
  logic [CHANNELS-1:0] wr_clear;
  logic [CHANNELS-1:0] wr_load;
  logic [CHANNELS-1:0] wr_mode;

  // Command FSM next state; ready follows whether the next state is IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE);
  end

  // Command FSM state and registered ready.
  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= ready_nxt;
    end
  end

  // Hold the accepted command for its EXEC cycle.
  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      op_q   <= OP_NOP;
      chan_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= cmd_op_t'(cmd_op);
      chan_q <= cmd_chan;
      data_q <= cmd_data;
    end
  end

  // Per-channel write strobes; out-of-range channels match nothing.
  always_comb begin
    wr_clear = '0;
    wr_load  = '0;
    wr_mode  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((state == EXEC) && chan_hit(chan_q, i)) begin
        wr_clear[i] = (op_q == OP_CLEAR);
        wr_load[i]  = (op_q == OP_LOAD);
        wr_mode[i]  = (op_q == OP_SET_MODE);
      end
    end
  end

  logic [WIDTH-1:0] live_count [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    slot_counter_channel #(
      .WIDTH (WIDTH)
    ) u_chan (
      .slower_clock (slower_clock),
      .rst          (rst),
      .count_en     (tick & enable[i]),
      .wr_clear     (wr_clear[i]),
      .wr_load      (wr_load[i]),
      .wr_mode      (wr_mode[i]),
      .data         (data_q),
      .count        (live_count[i]),
      .tc           (tc_pulse[i])
    );
  end

`ifdef SLOT_COUNTER_SNAPSHOT_EN
  logic [WIDTH-1:0] shadow [CHANNELS];

  // Shadows take the pre-edge live counts whenever snapshot is high.
  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) shadow[i] <= '0;
    end else if (snapshot) begin
      for (int i = 0; i < CHANNELS; i++) shadow[i] <= live_count[i];
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign count_out[i*SLOT_W +: SLOT_W] = SLOT_W'(shadow[i]);
  end
`else
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign count_out[i*SLOT_W +: SLOT_W] = SLOT_W'(live_count[i]);
  end
`endif

endmodule

// File: tb/tb_slot_counter_bank.sv
// Bench for slot_counter_bank: two instances (PRESCALE 1 and 4) share one
// stimulus stream and are compared every cycle against a reference model.
module tb_slot_counter_bank;

  localparam int CH   = 5;
  localparam int MAXV = 255;
  typedef logic [159:0] vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] enable;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_chan;
  logic [31:0]   cmd_data;
  logic          snapshot;

  logic          rdy0, rdy1;
  logic [159:0]  cnt0, cnt1;
  logic [CH-1:0] tc0, tc1;

  always #5 clk = ~clk;

  slot_counter_bank #(.CHANNELS(CH), .WIDTH(8), .PRESCALE(1)) dut0 (
    .slower_clock (clk),
    .rst          (rst),
    .enable       (enable),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (rdy0),
    .cmd_op       (cmd_op),
    .cmd_chan     (cmd_chan),
    .cmd_data     (cmd_data),
    .count_out    (cnt0),
    .tc_pulse     (tc0)
`ifdef SLOT_COUNTER_SNAPSHOT_EN
    ,
    .snapshot     (snapshot)
`endif
  );

  slot_counter_bank #(.CHANNELS(CH), .WIDTH(8), .PRESCALE(4)) dut1 (
    .slower_clock (clk),
    .rst          (rst),
    .enable       (enable),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (rdy1),
    .cmd_op       (cmd_op),
    .cmd_chan     (cmd_chan),
    .cmd_data     (cmd_data),
    .count_out    (cnt1),
    .tc_pulse     (tc1)
`ifdef SLOT_COUNTER_SNAPSHOT_EN
    ,
    .snapshot     (snapshot)
`endif
  );

  // Reference model state: index 0 is the PRESCALE=1 instance, 1 is PRESCALE=4.
  int         m_cnt [2][CH];
  int         m_sh  [2][CH];
  bit         m_dir [2][CH];
  bit         m_sat [2][CH];
  bit         m_tc  [2][CH];
  int         m_ps  [2];
  bit         m_ready, m_exec;
  int         m_op, m_chan;
  logic [31:0] m_data;

  int n_pass   = 0;
  int n_checks = 0;

  function automatic int ps_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ps[d] = 0;
      for (int c = 0; c < CH; c++) begin
        m_cnt[d][c] = 0; m_sh[d][c] = 0;
        m_dir[d][c] = 0; m_sat[d][c] = 0; m_tc[d][c] = 0;
      end
    end
    m_ready = 0; m_exec = 0; m_op = 0; m_chan = 0; m_data = '0;
  endfunction

  function automatic void model_edge(input logic r, input logic [CH-1:0] en,
                                     input logic v, input logic [1:0] op,
                                     input logic [7:0] chan, input logic [31:0] data,
                                     input logic snap);
    bit tick, tgt;
    int c0;
    if (r) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      tick = (m_ps[d] == ps_of(d) - 1);
      m_ps[d] = (m_ps[d] + 1) % ps_of(d);
      for (int c = 0; c < CH; c++) begin
        if (snap) m_sh[d][c] = m_cnt[d][c];
        tgt = m_exec && (m_chan == 255 || m_chan == c);
        c0  = m_cnt[d][c];
        if (tgt && m_op == 1) begin
          m_cnt[d][c] = 0; m_tc[d][c] = 0;
        end else if (tgt && m_op == 2) begin
          m_cnt[d][c] = int'(m_data[7:0]); m_tc[d][c] = 0;
        end else if (tgt && m_op == 3) begin
          m_dir[d][c] = m_data[0]; m_sat[d][c] = m_data[1]; m_tc[d][c] = 0;
        end else if (tick && en[c]) begin
          if (!m_dir[d][c]) begin
            if (m_sat[d][c]) begin
              if (c0 == MAXV) m_tc[d][c] = 0;
              else begin m_cnt[d][c] = c0 + 1; m_tc[d][c] = (c0 + 1 == MAXV); end
            end else begin
              m_tc[d][c] = (c0 == MAXV); m_cnt[d][c] = (c0 + 1) % 256;
            end
          end else begin
            if (m_sat[d][c]) begin
              if (c0 == 0) m_tc[d][c] = 0;
              else begin m_cnt[d][c] = c0 - 1; m_tc[d][c] = (c0 - 1 == 0); end
            end else begin
              m_tc[d][c] = (c0 == 0); m_cnt[d][c] = (c0 + 255) % 256;
            end
          end
        end else begin
          m_tc[d][c] = 0;
        end
      end
    end
    if (m_exec) begin
      m_exec = 0; m_ready = 1;
    end else if (v && m_ready) begin
      m_op = int'(op); m_chan = int'(chan); m_data = data;
      m_exec = 1; m_ready = 0;
    end else begin
      m_ready = 1;
    end
  endfunction

  function automatic vec_t exp_cnt(input int d);
    vec_t v = '0;
    for (int c = 0; c < CH; c++) begin
`ifdef SLOT_COUNTER_SNAPSHOT_EN
      v[32*c +: 32] = m_sh[d][c];
`else
      v[32*c +: 32] = m_cnt[d][c];
`endif
    end
    return v;
  endfunction

  function automatic vec_t exp_tc(input int d);
    vec_t v = '0;
    for (int c = 0; c < CH; c++) v[c] = m_tc[d][c];
    return v;
  endfunction

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("cnt_p1",   cnt0,          exp_cnt(0));
    check("cnt_p4",   cnt1,          exp_cnt(1));
    check("tc_p1",    vec_t'(tc0),   exp_tc(0));
    check("tc_p4",    vec_t'(tc1),   exp_tc(1));
    check("ready_p1", vec_t'(rdy0),  vec_t'(m_ready));
    check("ready_p4", vec_t'(rdy1),  vec_t'(m_ready));
  endtask

  // One clock edge: model sees the pre-edge inputs, outputs checked #1 later.
  task automatic cycle();
    logic r, v, s;
    logic [CH-1:0] e;
    logic [1:0] o;
    logic [7:0] ch;
    logic [31:0] dt;
    r = rst; e = enable; v = cmd_valid; o = cmd_op; ch = cmd_chan; dt = cmd_data; s = snapshot;
    @(posedge clk);
    model_edge(r, e, v, o, ch, dt, s);
    #1;
    check_all();
  endtask

  task automatic wait_handshake(input logic [1:0] op, input logic [7:0] chan, input logic [31:0] data);
    logic hs;
    hs = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_chan = chan; cmd_data = data;
    for (int k = 0; k < 8 && !hs; k++) begin
      hs = rdy0;
      cycle();
    end
    cmd_valid = 1'b0;
    check("handshake_seen", vec_t'(hs), vec_t'(1'b1));
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] chan, input logic [31:0] data);
    wait_handshake(op, chan, data);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = '0; cmd_valid = 1'b0; cmd_op = '0; cmd_chan = '0;
    cmd_data = '0; snapshot = 1'b0;
    model_reset();

    // Reset and first ready edge.
    repeat (3) cycle();
    rst = 1'b0;
    check("ready_first_cycle", vec_t'(rdy0), vec_t'(1'b0));
    check("cnt_after_rst",     cnt0,         vec_t'(0));
    check("tc_after_rst",      vec_t'(tc0),  vec_t'(0));
    cycle();
    check("ready_after_edge",  vec_t'(rdy0), vec_t'(1'b1));

    // Up/wrap across FF -> 00 on channel 0.
    send_cmd(2'd2, 8'd0, 32'hFE);
`ifndef SLOT_COUNTER_SNAPSHOT_EN
    check("wrap_fe", vec_t'(cnt0[7:0]), vec_t'(8'hFE));
`endif
    enable = 5'b00001;
    cycle();
`ifndef SLOT_COUNTER_SNAPSHOT_EN
    check("wrap_ff", vec_t'(cnt0[7:0]), vec_t'(8'hFF));
`endif
    check("wrap_tc_ff", vec_t'(tc0[0]), vec_t'(1'b0));
    cycle();
`ifndef SLOT_COUNTER_SNAPSHOT_EN
    check("wrap_00", vec_t'(cnt0[7:0]), vec_t'(8'h00));
`endif
    check("wrap_tc_00", vec_t'(tc0[0]), vec_t'(1'b1));
    cycle();
    check("wrap_tc_01", vec_t'(tc0[0]), vec_t'(1'b0));

    // Down/saturate on channel 2.
    enable = '0;
    send_cmd(2'd3, 8'd2, 32'd3);
    send_cmd(2'd2, 8'd2, 32'd2);
    enable = 5'b00100;
    cycle();
    check("sat_tc_1", vec_t'(tc0[2]), vec_t'(1'b0));
    cycle();
    check("sat_tc_0", vec_t'(tc0[2]), vec_t'(1'b1));
`ifndef SLOT_COUNTER_SNAPSHOT_EN
    check("sat_cnt_0", vec_t'(cnt0[64 +: 8]), vec_t'(8'h00));
`endif
    repeat (2) begin
      cycle();
      check("sat_tc_held", vec_t'(tc0[2]), vec_t'(1'b0));
    end

    // Broadcast CLEAR whose EXEC edge coincides with a PRESCALE=4 tick.
    enable = '1;
    for (int k = 0; k < 8 && !(m_ps[1] == 2 && m_ready); k++) cycle();
    send_cmd(2'd1, 8'hFF, 32'd0);
`ifndef SLOT_COUNTER_SNAPSHOT_EN
    check("coll_cnt", cnt1, vec_t'(0));
`endif
    check("coll_tc", vec_t'(tc1), vec_t'(0));
    repeat (3) cycle();
`ifndef SLOT_COUNTER_SNAPSHOT_EN
    check("coll_hold", vec_t'(cnt1[7:0]), vec_t'(8'h00));
`endif
    cycle();
`ifndef SLOT_COUNTER_SNAPSHOT_EN
    check("coll_next", vec_t'(cnt1[7:0]), vec_t'(8'h01));
`endif

    // Out-of-range channel, then back-to-back commands with valid held.
    enable = '0;
    send_cmd(2'd2, 8'd9, 32'h55);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_chan = 8'd1; cmd_data = 32'h11;
    check("b2b_r0", vec_t'(rdy0), vec_t'(1'b1));
    cycle();
    check("b2b_r1", vec_t'(rdy0), vec_t'(1'b0));
    cmd_chan = 8'd3; cmd_data = 32'h33;
    cycle();
    check("b2b_r2", vec_t'(rdy0), vec_t'(1'b1));
`ifndef SLOT_COUNTER_SNAPSHOT_EN
    check("b2b_ch1", vec_t'(cnt0[32 +: 8]), vec_t'(8'h11));
`endif
    cycle();
    check("b2b_r3", vec_t'(rdy0), vec_t'(1'b0));
    cmd_valid = 1'b0;
    cycle();
`ifndef SLOT_COUNTER_SNAPSHOT_EN
    check("b2b_ch3", vec_t'(cnt0[96 +: 8]), vec_t'(8'h33));
`endif

`ifdef SLOT_COUNTER_SNAPSHOT_EN
    // Snapshot holds 0x10 while the live counter runs on.
    send_cmd(2'd3, 8'd0, 32'd0);
    send_cmd(2'd2, 8'd0, 32'h10);
    enable = 5'b00001; snapshot = 1'b1;
    cycle();
    check("snap_10", vec_t'(cnt0[7:0]), vec_t'(8'h10));
    snapshot = 1'b0;
    repeat (3) cycle();
    check("snap_hold", vec_t'(cnt0[7:0]), vec_t'(8'h10));
    snapshot = 1'b1;
    cycle();
    check("snap_14", vec_t'(cnt0[7:0]), vec_t'(8'h14));
    snapshot = 1'b0;
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      int sel;
      enable    = CH'($urandom);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      sel       = $urandom_range(0, 7);
      if (sel < CH)       cmd_chan = 8'(sel);
      else if (sel == 5)  cmd_chan = 8'd9;
      else if (sel == 6)  cmd_chan = 8'hFF;
      else                cmd_chan = 8'($urandom);
      cmd_data  = $urandom;
      snapshot  = ($urandom_range(0, 3) == 0);
      cycle();
    end
    cmd_valid = 1'b0; snapshot = 1'b0;
    cycle();

    // Reset asserted while a command is pending in EXEC.
    enable = '1;
    wait_handshake(2'd2, 8'hFF, 32'hAA);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
    check("ready_after_rerst", vec_t'(rdy0), vec_t'(1'b0));
    repeat (6) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
